// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the calculator-datapath register file.
// Holds the default geometry and build options that the top and the
// scoreboard take as parameter defaults, so every user agrees on one set.
package regfile_sb_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NREG    = 4;
  localparam int DEF_AW      = 2;
  localparam bit DEF_ZERO_R0 = 1'b0;
  localparam bit DEF_BYPASS  = 1'b1;

endpackage

// File: rtl/regfile_sb_score.sv
// Busy scoreboard for regfile_sb.
// Tracks issued-but-unwritten destinations, keeps a registered popcount of
// them, and raises a combinational stall for RAW (read ports) and WAW
// (issue port) hazards.
// Ports:
//   ck, res          clock (rising) / async active-low reset
//   rsel_a/b, use_a/b read selects and operand-needed qualifiers
//   wsel, we         write select / write enable (active-low)
//   isel, iss        issue destination / issue strobe (active-low)
//   stall            hazard, issue must be held
//   busy, nbusy      registered busy vector and its popcount
module regfile_sb_score
  import regfile_sb_pkg::*;
#(
  parameter int NREG    = DEF_NREG,
  parameter int AW      = DEF_AW,
  parameter bit ZERO_R0 = DEF_ZERO_R0,
  parameter bit BYPASS  = DEF_BYPASS
) (
  input  logic            ck,
  input  logic            res,
  input  logic [AW-1:0]   rsel_a,
  input  logic [AW-1:0]   rsel_b,
  input  logic            use_a,
  input  logic            use_b,
  input  logic [AW-1:0]   wsel,
  input  logic            we,
  input  logic [AW-1:0]   isel,
  input  logic            iss,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     nbusy
);

  logic            wr, eff_a, eff_b, waw, accept;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;

  assign wr = ~we;

  // A same-cycle write to the selected register satisfies the read only
  // when the value is forwarded; otherwise the read still sees stale data.
  assign eff_a = busy[rsel_a] & ~(BYPASS & wr & (wsel == rsel_a));
  assign eff_b = busy[rsel_b] & ~(BYPASS & wr & (wsel == rsel_b));

  // WAW: the pending result lands this very cycle, so reissuing is safe.
  assign waw    = ~iss & busy[isel] & ~(wr & (wsel == isel));
  assign stall  = (use_a & eff_a) | (use_b & eff_b) | waw;
  assign accept = ~iss & ~stall;

  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (wr && wsel == AW'(i))     busy_nxt[i] = 1'b0;
      // set after clear: a new issue outranks the completing write
      if (accept && isel == AW'(i)) busy_nxt[i] = 1'b1;
      if (ZERO_R0 && i == 0)        busy_nxt[i] = 1'b0;
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  // count registered alongside busy so it never lags the vector
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      busy  <= '0;
      nbusy <= '0;
    end else begin
      busy  <= busy_nxt;
      nbusy <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// 2-read / 1-write register file with busy scoreboard.
// Storage, write decode, combinational read muxes and write-to-read bypass
// live here; hazard tracking is in regfile_sb_score.
// Ports:
//   ck, res          clock (rising) / async active-low reset
//   rsel_a/b, q_a/b  read selects and data (0-cycle)
//   use_a/b          operand-needed qualifiers for stall
//   wsel, d, we      write select, data, enable (active-low)
//   isel, iss        issue destination / strobe (active-low)
//   stall, busy, nbusy  scoreboard outputs
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREG    = DEF_NREG,
  parameter int AW      = DEF_AW,
  parameter bit ZERO_R0 = DEF_ZERO_R0,
  parameter bit BYPASS  = DEF_BYPASS
) (
  input  logic             ck,
  input  logic             res,
  input  logic [AW-1:0]    rsel_a,
  input  logic [AW-1:0]    rsel_b,
  input  logic             use_a,
  input  logic             use_b,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] d,
  input  logic             we,
  input  logic [AW-1:0]    isel,
  input  logic             iss,
  output logic             stall,
  output logic [NREG-1:0]  busy,
  output logic [AW:0]      nbusy
);

  logic [NREG-1:0][WIDTH-1:0] rf;
  logic [1:0][AW-1:0]         rsel;
  logic [1:0][WIDTH-1:0]      q;

  always_ff @(posedge ck or negedge res) begin
    if (!res)                                   rf <= '0;
    else if (!we && !(ZERO_R0 && wsel == '0))   rf[wsel] <= d;
  end

  assign rsel = {rsel_b, rsel_a};

  // hardwired-zero r0 overrides the bypass path
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      q[p] = rf[rsel[p]];
      if (BYPASS && !we && wsel == rsel[p]) q[p] = d;
      if (ZERO_R0 && rsel[p] == '0)         q[p] = '0;
    end
  end

  assign q_a = q[0];
  assign q_b = q[1];

  regfile_sb_score #(
    .NREG(NREG), .AW(AW), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
  ) u_score (
    .ck(ck), .res(res),
    .rsel_a(rsel_a), .rsel_b(rsel_b), .use_a(use_a), .use_b(use_b),
    .wsel(wsel), .we(we), .isel(isel), .iss(iss),
    .stall(stall), .busy(busy), .nbusy(nbusy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two builds (default, and ZERO_R0=1/BYPASS=0) share
// one stimulus stream and are compared against a behavioural model.
module tb_regfile_sb;

  logic        ck = 1'b0;
  logic        res = 1'b0;
  logic [1:0]  rsel_a = '0, rsel_b = '0, wsel = '0, isel = '0;
  logic        use_a = 1'b0, use_b = 1'b0, we = 1'b1, iss = 1'b1;
  logic [15:0] d = '0;

  logic [15:0] q_a0, q_b0, q_a1, q_b1;
  logic        stall0, stall1;
  logic [3:0]  busy0, busy1;
  logic [2:0]  nbusy0, nbusy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ck = ~ck;

  regfile_sb dut (
    .ck(ck), .res(res), .rsel_a(rsel_a), .rsel_b(rsel_b), .use_a(use_a), .use_b(use_b),
    .q_a(q_a0), .q_b(q_b0), .wsel(wsel), .d(d), .we(we), .isel(isel), .iss(iss),
    .stall(stall0), .busy(busy0), .nbusy(nbusy0)
  );

  regfile_sb #(.ZERO_R0(1'b1), .BYPASS(1'b0)) dut_z (
    .ck(ck), .res(res), .rsel_a(rsel_a), .rsel_b(rsel_b), .use_a(use_a), .use_b(use_b),
    .q_a(q_a1), .q_b(q_b1), .wsel(wsel), .d(d), .we(we), .isel(isel), .iss(iss),
    .stall(stall1), .busy(busy1), .nbusy(nbusy1)
  );

  // ---- reference model: index 0 = default build, 1 = zero-r0/no-bypass ----
  logic [15:0] m_reg  [2][4];
  logic        m_busy [2][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_q(int c, logic [1:0] rs);
    if (c == 1 && rs == 0)                 return 16'h0;
    if (c == 0 && !we && wsel == rs)       return d;
    return m_reg[c][rs];
  endfunction

  function automatic logic m_stall(int c);
    logic ea, eb, w;
    ea = m_busy[c][rsel_a] && !(c == 0 && !we && wsel == rsel_a);
    eb = m_busy[c][rsel_b] && !(c == 0 && !we && wsel == rsel_b);
    w  = !iss && m_busy[c][isel] && !(!we && wsel == isel);
    return (use_a && ea) || (use_b && eb) || w;
  endfunction

  function automatic logic [3:0] m_busy_vec(int c);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_busy[c][i];
    return v;
  endfunction

  function automatic int m_cnt(int c);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m_busy[c][i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        m_reg[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  // apply inputs (just after a falling edge), then check combinational outputs
  task automatic drive(input logic [1:0] ra, input logic [1:0] rb, input logic ua,
                       input logic ub, input logic [1:0] ws, input logic [15:0] dd,
                       input logic w, input logic is, input logic [1:0] i);
    rsel_a = ra; rsel_b = rb; use_a = ua; use_b = ub;
    wsel = ws; d = dd; we = w; iss = is; isel = i;
    #1;
    chk("q_a",    q_a0,   m_q(0, rsel_a));
    chk("q_b",    q_b0,   m_q(0, rsel_b));
    chk("stall",  stall0, m_stall(0));
    chk("z.q_a",  q_a1,   m_q(1, rsel_a));
    chk("z.q_b",  q_b1,   m_q(1, rsel_b));
    chk("z.stall",stall1, m_stall(1));
  endtask

  // advance one clock, update model from the inputs seen at the edge
  task automatic tick();
    logic st [2];
    for (int c = 0; c < 2; c++) st[c] = m_stall(c);
    @(posedge ck);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (!we && !(c == 1 && wsel == 0)) begin
        m_reg[c][wsel]  = d;
        m_busy[c][wsel] = 1'b0;
      end
      if (!iss && !st[c] && !(c == 1 && isel == 0)) m_busy[c][isel] = 1'b1;
    end
    chk("busy",    32'(busy0),  32'(m_busy_vec(0)));
    chk("nbusy",   32'(nbusy0), 32'(m_cnt(0)));
    chk("z.busy",  32'(busy1),  32'(m_busy_vec(1)));
    chk("z.nbusy", 32'(nbusy1), 32'(m_cnt(1)));
    @(negedge ck);
  endtask

  task automatic idle();
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge ck);
    res = 1'b1;

    // 1: reset state
    for (int r = 0; r < 4; r++) begin
      drive(2'(r), 2'(r), 1'b1, 1'b1, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
      chk("rst.q_a", q_a0, 32'h0);
      chk("rst.q_b", q_b0, 32'h0);
    end
    chk("rst.busy", 32'(busy0), 32'h0);
    chk("rst.nbusy", 32'(nbusy0), 32'h0);
    chk("rst.stall", 32'(stall0), 32'h0);

    // 2: bypass vs. no-bypass on a same-cycle write
    drive(2'd2, 2'd0, 1'b0, 1'b0, 2'd2, 16'h1234, 1'b0, 1'b1, 2'd0);
    chk("byp.q_a", q_a0, 32'h1234);
    chk("nobyp.q_a", q_a1, 32'h0);
    tick();
    drive(2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
    chk("wr.q_a", q_a0, 32'h1234);
    chk("z.wr.q_a", q_a1, 32'h1234);

    // 3: issue r1, RAW stall qualified by use_a, write clears busy
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 2'd1);
    tick();
    chk("iss.busy", 32'(busy0), 32'h2);
    chk("iss.nbusy", 32'(nbusy0), 32'h1);
    drive(2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
    chk("raw.stall", 32'(stall0), 32'h1);
    drive(2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
    chk("raw.nouse", 32'(stall0), 32'h0);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 16'h00AA, 1'b0, 1'b1, 2'd0);
    tick();
    chk("clr.busy", 32'(busy0), 32'h0);
    chk("clr.nbusy", 32'(nbusy0), 32'h0);

    // 4: WAW on r3, released by a same-cycle write to r3
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 2'd3);
    tick();
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 2'd3);
    chk("waw.stall", 32'(stall0), 32'h1);
    tick();
    chk("waw.busy", 32'(busy0), 32'h8);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 16'h5A5A, 1'b0, 1'b0, 2'd3);
    chk("waw.wr.stall", 32'(stall0), 32'h0);
    tick();
    chk("waw.set.busy", 32'(busy0), 32'h8);
    drive(2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
    chk("waw.r3", q_a0, 32'h5A5A);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 16'h0003, 1'b0, 1'b1, 2'd0);
    tick();

    // 5: r0 writes/issues ignored on the zero-r0 build
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'hFFFF, 1'b0, 1'b0, 2'd0);
    chk("z0.q_a", q_a1, 32'h0);
    tick();
    chk("z0.busy0", 32'(busy1[0]), 32'h0);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
    chk("z0.rd", q_a1, 32'h0);
    chk("r0.rd", q_a0, 32'hFFFF);
    drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0);
    tick();

    // 6: back-to-back issue then asynchronous reset between edges
    for (int r = 0; r < 4; r++) begin
      drive(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 2'(r));
      tick();
      chk("seq.nbusy", 32'(nbusy0), 32'(r + 1));
    end
    drive(2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 2'd0);
    #2 res = 1'b0;
    #1;
    chk("arst.busy", 32'(busy0), 32'h0);
    chk("arst.nbusy", 32'(nbusy0), 32'h0);
    chk("arst.z.busy", 32'(busy1), 32'h0);
    for (int r = 0; r < 4; r++) begin
      rsel_a = 2'(r); rsel_b = 2'(3 - r);
      #1;
      chk("arst.q_a", q_a0, 32'h0);
      chk("arst.q_b", q_b0, 32'h0);
    end
    m_reset();
    @(negedge ck);
    res = 1'b1;
    idle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 16'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard stop in case anything above stalls
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
